// File: rtl/cache_mem_bridge_if.sv
// Cache-side and memory-side handshake signals of the cache/memory bridge.
// slave = bridge view; master = the cache pair plus memory port that surround it.
interface cache_mem_bridge_if;
  logic        inst_interface_call_begin;
  logic [31:0] inst_interface_addr;
  logic        inst_interface_return_ready;
  logic [31:0] inst_interface_rdata;
  logic        data_interface_enable;
  logic        data_interface_call_begin;
  logic        write_enable;
  logic [2:0]  read_size;
  logic [2:0]  write_size;
  logic [31:0] data_interface_raddr;
  logic [31:0] data_interface_waddr;
  logic [31:0] data_interface_wdata;
  logic        data_interface_return_ready;
  logic [31:0] data_interface_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_interface_call_begin, inst_interface_addr,
    output inst_interface_return_ready, inst_interface_rdata,
    input  data_interface_enable, data_interface_call_begin, write_enable,
    input  read_size, write_size, data_interface_raddr, data_interface_waddr,
    input  data_interface_wdata,
    output data_interface_return_ready, data_interface_rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_interface_call_begin, inst_interface_addr,
    input  inst_interface_return_ready, inst_interface_rdata,
    output data_interface_enable, data_interface_call_begin, write_enable,
    output read_size, write_size, data_interface_raddr, data_interface_waddr,
    output data_interface_wdata,
    input  data_interface_return_ready, data_interface_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/cache_mem_bridge.sv
// Buffers inst/data cache requests and serialises them onto one memory port; min 2 cycles call->return.
// One transaction in flight; mem_req held until mem_addr_ok, a busy source's repeated call_begin is dropped.
module cache_mem_bridge (
  input  logic                clk,
  input  logic                reset,
  cache_mem_bridge_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;          // 1 = data cache owns the in-flight transaction
  logic        inst_pend_q, inst_pend_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        data_pend_q, data_pend_d;
  logic        data_wr_q, data_wr_d;
  logic [1:0]  data_size_q, data_size_d;
  logic [31:0] data_addr_q, data_addr_d;
  logic [31:0] data_wdata_q, data_wdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_wr_q, mem_wr_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        inst_ret_q, inst_ret_d;
  logic        data_ret_q, data_ret_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic        inst_new, data_new;
  logic        data_wr_eff;
  logic [1:0]  data_size_eff;
  logic [31:0] inst_addr_eff, data_addr_eff, data_wdata_eff;
  logic [31:0] rsp_dat;

  function automatic logic [1:0] map_size(input logic [2:0] s);
    case (s)
      3'd0:    return 2'd0;
      3'd1:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  always_comb begin
    inst_new = bus.inst_interface_call_begin & ~inst_pend_q &
               ~((state_q != S_IDLE) & ~owner_q);
    data_new = bus.data_interface_enable & bus.data_interface_call_begin & ~data_pend_q &
               ~((state_q != S_IDLE) & owner_q);
    inst_addr_eff  = inst_new ? bus.inst_interface_addr : inst_addr_q;
    data_wr_eff    = data_new ? bus.write_enable : data_wr_q;
    data_size_eff  = data_new ? map_size(bus.write_enable ? bus.write_size : bus.read_size)
                              : data_size_q;
    data_addr_eff  = data_new ? (bus.write_enable ? bus.data_interface_waddr
                                                  : bus.data_interface_raddr)
                              : data_addr_q;
    data_wdata_eff = data_new ? bus.data_interface_wdata : data_wdata_q;
    rsp_dat        = mem_wr_q ? 32'd0 : bus.mem_rdata;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    inst_pend_d  = inst_pend_q | inst_new;
    inst_addr_d  = inst_addr_eff;
    data_pend_d  = data_pend_q | data_new;
    data_wr_d    = data_wr_eff;
    data_size_d  = data_size_eff;
    data_addr_d  = data_addr_eff;
    data_wdata_d = data_wdata_eff;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_size_d   = mem_size_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_ret_d   = 1'b0;
    data_ret_d   = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (data_pend_q | data_new) begin
          data_pend_d = 1'b0;
          owner_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_wr_d    = data_wr_eff;
          mem_size_d  = data_size_eff;
          mem_addr_d  = data_addr_eff;
          mem_wdata_d = data_wdata_eff;
          state_d     = S_REQ;
        end else if (inst_pend_q | inst_new) begin
          inst_pend_d = 1'b0;
          owner_d     = 1'b0;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_size_d  = 2'd2;
          mem_addr_d  = inst_addr_eff;
          mem_wdata_d = 32'd0;
          state_d     = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        if (state_q == S_REQ && bus.mem_addr_ok) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end
        // Data phase may complete in the same cycle the address is accepted.
        if ((state_q == S_WAIT || bus.mem_addr_ok) && bus.mem_data_ok) begin
          state_d = S_RESP;
          if (owner_q) begin
            data_rdata_d = rsp_dat;
            data_ret_d   = 1'b1;
          end else begin
            inst_rdata_d = rsp_dat;
            inst_ret_d   = 1'b1;
          end
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      inst_pend_q  <= 1'b0;
      inst_addr_q  <= 32'd0;
      data_pend_q  <= 1'b0;
      data_wr_q    <= 1'b0;
      data_size_q  <= 2'd0;
      data_addr_q  <= 32'd0;
      data_wdata_q <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_size_q   <= 2'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      inst_ret_q   <= 1'b0;
      data_ret_q   <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      inst_pend_q  <= inst_pend_d;
      inst_addr_q  <= inst_addr_d;
      data_pend_q  <= data_pend_d;
      data_wr_q    <= data_wr_d;
      data_size_q  <= data_size_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_size_q   <= mem_size_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_ret_q   <= inst_ret_d;
      data_ret_q   <= data_ret_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign bus.mem_req                     = mem_req_q;
  assign bus.mem_wr                      = mem_wr_q;
  assign bus.mem_size                    = mem_size_q;
  assign bus.mem_addr                    = mem_addr_q;
  assign bus.mem_wdata                   = mem_wdata_q;
  assign bus.inst_interface_return_ready = inst_ret_q;
  assign bus.inst_interface_rdata        = inst_rdata_q;
  assign bus.data_interface_return_ready = data_ret_q;
  assign bus.data_interface_rdata        = data_rdata_q;

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge: a memory responder checks issued requests, a monitor
// checks each return_ready pulse against the expected-response queue.
module tb_cache_mem_bridge;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          aok;
    int          dok;
  } mem_exp_t;

  typedef struct {
    logic        src;     // 1 = data cache
    logic [31:0] rdata;
    int          t0;
    int          lat;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   unexp_cnt = 0;
  bit   auto_mode = 1'b0;
  logic inst_prev = 1'b0;
  logic data_prev = 1'b0;

  mem_exp_t memq[$];
  rsp_exp_t respq[$];

  cache_mem_bridge_if bus();

  cache_mem_bridge u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_req"},    32'(bus.mem_req), 32'd0);
    chk({tag, "_mem_wr"},     32'(bus.mem_wr), 32'd0);
    chk({tag, "_mem_size"},   32'(bus.mem_size), 32'd0);
    chk({tag, "_mem_addr"},   bus.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"},  bus.mem_wdata, 32'd0);
    chk({tag, "_inst_rdy"},   32'(bus.inst_interface_return_ready), 32'd0);
    chk({tag, "_data_rdy"},   32'(bus.data_interface_return_ready), 32'd0);
    chk({tag, "_inst_rdata"}, bus.inst_interface_rdata, 32'd0);
    chk({tag, "_data_rdata"}, bus.data_interface_rdata, 32'd0);
  endtask

  // Memory responder: compares each new request, holds addr_ok off for aok cycles, then data_ok after dok.
  initial begin
    mem_exp_t m;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = 32'd0;
    forever begin
      @(negedge clk);
      if (auto_mode && bus.mem_req === 1'b1) begin
        if (memq.size() == 0) begin
          unexp_cnt++;
        end else begin
          m = memq.pop_front();
          chk("mem_wr",   32'(bus.mem_wr), 32'(m.wr));
          chk("mem_size", 32'(bus.mem_size), 32'(m.size));
          chk("mem_addr", bus.mem_addr, m.addr);
          if (m.wr) chk("mem_wdata", bus.mem_wdata, m.wdata);
          for (int i = 0; i < m.aok; i++) begin
            @(negedge clk);
            chk("hold_req",  32'(bus.mem_req), 32'd1);
            chk("hold_addr", bus.mem_addr, m.addr);
            chk("hold_size", 32'(bus.mem_size), 32'(m.size));
          end
          bus.mem_addr_ok = 1'b1;
          if (m.dok == 0) begin
            bus.mem_data_ok = 1'b1;
            bus.mem_rdata   = m.rdata;
          end
          @(negedge clk);
          bus.mem_addr_ok = 1'b0;
          bus.mem_data_ok = 1'b0;
          chk("req_drop", 32'(bus.mem_req), 32'd0);
          if (m.dok > 0) begin
            for (int i = 1; i < m.dok; i++) @(negedge clk);
            bus.mem_data_ok = 1'b1;
            bus.mem_rdata   = m.rdata;
            @(negedge clk);
            bus.mem_data_ok = 1'b0;
          end
        end
      end
    end
  end

  task automatic handle_rsp(input logic src, input logic [31:0] rdata, input logic prev);
    rsp_exp_t e;
    chk(src ? "data_pulse_width" : "inst_pulse_width", 32'(prev), 32'd0);
    if (respq.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_rsp: src %0d rdata %h, none expected", src, rdata);
    end else begin
      e = respq.pop_front();
      chk("rsp_src",   32'(src), 32'(e.src));
      chk("rsp_rdata", rdata, e.rdata);
      chk("rsp_lat",   32'(cyc - e.t0), 32'(e.lat));
    end
  endtask

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.data_interface_return_ready === 1'b1)
        handle_rsp(1'b1, bus.data_interface_rdata, data_prev);
      if (bus.inst_interface_return_ready === 1'b1)
        handle_rsp(1'b0, bus.inst_interface_rdata, inst_prev);
      data_prev <= bus.data_interface_return_ready;
      inst_prev <= bus.inst_interface_return_ready;
    end
  end

  task automatic push_inst(input logic [31:0] addr, input logic [31:0] rdata,
                           input int aok, input int dok, input int lat);
    memq.push_back('{1'b0, 2'd2, addr, 32'd0, rdata, aok, dok});
    respq.push_back('{1'b0, rdata, cyc, lat});
    bus.inst_interface_call_begin = 1'b1;
    bus.inst_interface_addr       = addr;
  endtask

  task automatic push_load(input logic [31:0] addr, input logic [2:0] size, input logic [1:0] esize,
                           input logic [31:0] rdata, input int aok, input int dok, input int lat);
    memq.push_back('{1'b0, esize, addr, 32'd0, rdata, aok, dok});
    respq.push_back('{1'b1, rdata, cyc, lat});
    bus.data_interface_call_begin = 1'b1;
    bus.write_enable              = 1'b0;
    bus.read_size                 = size;
    bus.write_size                = 3'd0;
    bus.data_interface_raddr      = addr;
    bus.data_interface_waddr      = 32'h0000_0999;
  endtask

  task automatic push_store(input logic [31:0] addr, input logic [2:0] size, input logic [1:0] esize,
                            input logic [31:0] wdata, input logic [31:0] mem_rd,
                            input int aok, input int dok, input int lat);
    memq.push_back('{1'b1, esize, addr, wdata, mem_rd, aok, dok});
    respq.push_back('{1'b1, 32'd0, cyc, lat});
    bus.data_interface_call_begin = 1'b1;
    bus.write_enable              = 1'b1;
    bus.write_size                = size;
    bus.read_size                 = 3'd2;
    bus.data_interface_waddr      = addr;
    bus.data_interface_raddr      = 32'h0000_0888;
    bus.data_interface_wdata      = wdata;
  endtask

  task automatic tick();
    @(negedge clk);
    bus.inst_interface_call_begin = 1'b0;
    bus.data_interface_call_begin = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && (respq.size() != 0 || memq.size() != 0); i++) @(negedge clk);
    chk("drain_timeout", 32'(respq.size() + memq.size()), 32'd0);
    respq.delete();
    memq.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    bus.inst_interface_call_begin = 1'b0;
    bus.inst_interface_addr       = 32'd0;
    bus.data_interface_enable     = 1'b1;
    bus.data_interface_call_begin = 1'b0;
    bus.write_enable              = 1'b0;
    bus.read_size                 = 3'd0;
    bus.write_size                = 3'd0;
    bus.data_interface_raddr      = 32'd0;
    bus.data_interface_waddr      = 32'd0;
    bus.data_interface_wdata      = 32'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset     = 1'b1;
    auto_mode = 1'b1;
    @(negedge clk);

    // inst fetch, data_ok two cycles after addr_ok
    push_inst(32'h0000_1000, 32'h2402_0005, 0, 2, 4);
    tick();
    wait_done(50);

    // byte store: memory drives junk rdata, cache must see 0
    push_store(32'h0000_2003, 3'd0, 2'd0, 32'h0000_00AB, 32'hCAFE_BABE, 0, 1, 3);
    tick();
    wait_done(50);

    // simultaneous: data wins, inst follows from pending
    push_load(32'h0000_0200, 3'd2, 2'd2, 32'hDEAD_BEEF, 0, 1, 3);
    push_inst(32'h0000_0100, 32'h1111_2222, 0, 1, 7);
    tick();
    wait_done(50);

    // addr_ok withheld 5 cycles, half-word load
    push_load(32'h0000_3002, 3'd1, 2'd1, 32'h0000_BEEF, 5, 0, 7);
    tick();
    wait_done(50);

    // zero-latency addr_ok+data_ok, size code 5 treated as word
    push_load(32'h0000_4000, 3'd5, 2'd2, 32'h0BAD_F00D, 0, 0, 2);
    tick();
    wait_done(50);

    // data call_begin with enable low must not issue
    bus.data_interface_enable     = 1'b0;
    bus.data_interface_call_begin = 1'b1;
    bus.write_enable              = 1'b0;
    bus.data_interface_raddr      = 32'h0000_0600;
    tick();
    repeat (6) @(negedge clk);
    bus.data_interface_enable = 1'b1;

    // duplicate inst call_begin while the first fetch is in flight
    push_inst(32'h0000_0400, 32'h55AA_55AA, 1, 1, 4);
    tick();
    @(negedge clk);
    bus.inst_interface_call_begin = 1'b1;
    bus.inst_interface_addr       = 32'h0000_0500;
    tick();
    wait_done(50);
    repeat (4) @(negedge clk);

    // reset while waiting for data_ok; the late data_ok must be discarded
    auto_mode = 1'b0;
    bus.inst_interface_call_begin = 1'b1;
    bus.inst_interface_addr       = 32'h0000_0700;
    tick();
    chk("rst_seq_req", 32'(bus.mem_req), 32'd1);
    bus.mem_addr_ok = 1'b1;
    @(negedge clk);
    bus.mem_addr_ok = 1'b0;
    chk("rst_seq_wait", 32'(bus.mem_req), 32'd0);
    reset = 1'b0;
    #1;
    check_zero("rst_in_wait");
    @(negedge clk);
    reset           = 1'b1;
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_inst_rdy", 32'(bus.inst_interface_return_ready), 32'd0);
      chk("post_rst_mem_req",  32'(bus.mem_req), 32'd0);
    end
    auto_mode = 1'b1;

    // normal operation after reset
    push_inst(32'h0000_0800, 32'h1234_5678, 0, 1, 3);
    tick();
    wait_done(50);

    chk("stray_mem_req", 32'(unexp_cnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
